// File: rtl/half_norm_round.sv
// Normalise-and-round stage for the binary16 multiplier: one normalisation
// shift per clock, then a single round-to-nearest-even step into a packed result.
module half_norm_round #(
  parameter int unsigned MANT_W = 20,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inexact
);

  localparam int unsigned EXPI_W = EXP_W + 2;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned LOW_W  = MANT_W - FRAC_W - 3;

  localparam logic signed [EXPI_W-1:0] EXP_ZERO = EXPI_W'(0);
  localparam logic signed [EXPI_W-1:0] EXP_ONE  = EXPI_W'(1);
  localparam logic signed [EXPI_W-1:0] EXP_MAX  = EXPI_W'(31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic signed [EXPI_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0]         mant_q, mant_d;
  logic                      sticky_q, sticky_d;
  logic                      zero_q, zero_d;
  logic                      unnorm_q, unnorm_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [15:0]               out_data_q, out_data_d;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;
  logic                      inexact_q, inexact_d;

  logic [FRAC_W-1:0]         frac;
  logic                      guard;
  logic                      sticky_all;
  logic                      round_up;
  logic [FRAC_W:0]           frac_rnd;
  logic signed [EXPI_W-1:0]  exp_rnd;

  // Rounding datapath, consumed only in ROUND.
  always_comb begin
    frac       = mant_q[MANT_W-3 -: FRAC_W];
    guard      = mant_q[MANT_W-FRAC_W-3];
    sticky_all = sticky_q | (|mant_q[LOW_W-1:0]);
    round_up   = guard & (sticky_all | frac[0]);
    frac_rnd   = {1'b0, frac} + (FRAC_W+1)'(round_up);
    exp_rnd    = exp_q + (frac_rnd[FRAC_W] ? EXP_ONE : EXP_ZERO);
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    sticky_d    = sticky_q;
    zero_d      = zero_q;
    unnorm_d    = unnorm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inexact_d   = inexact_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = {{2{in_exp[EXP_W-1]}}, in_exp};
          mant_d   = in_mant;
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          unnorm_d = 1'b0;
          state_d  = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (mant_q[MANT_W-1]) begin
          mant_d   = {1'b0, mant_q[MANT_W-1:1]};
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + EXP_ONE;
        end else if (mant_q[MANT_W-2]) begin
          state_d = ROUND;
        end else if (exp_q > EXP_ONE) begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end else begin
          unnorm_d = 1'b1;
          state_d  = ROUND;
        end
      end

      ROUND: begin
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        inexact_d = guard | sticky_all;
        if (zero_q) begin
          out_data_d = {sign_q, 15'b0};
        end else if (unnorm_q || (exp_rnd <= EXP_ZERO)) begin
          out_data_d = {sign_q, 15'b0};
          unf_d      = 1'b1;
          inexact_d  = 1'b1;
        end else if (exp_rnd >= EXP_MAX) begin
          out_data_d = {sign_q, 5'h1F, 10'b0};
          ovf_d      = 1'b1;
          inexact_d  = 1'b1;
        end else begin
          out_data_d = {sign_q, exp_rnd[4:0], frac_rnd[FRAC_W-1:0]};
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      sticky_q    <= 1'b0;
      zero_q      <= 1'b0;
      unnorm_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      sticky_q    <= sticky_d;
      zero_q      <= zero_d;
      unnorm_q    <= unnorm_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inexact_q   <= inexact_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = ovf_q;
  assign out_unf     = unf_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_half_norm_round.sv
// Self-checking bench for half_norm_round: directed cases, reset abort and
// random words compared against an arithmetic rounding model.
module tb_half_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [19:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  half_norm_round #(.MANT_W(20), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf),
    .out_inexact(out_inexact)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  // Value = m * 2^(e-15-18). Keep the 11 most significant bits, round the rest.
  task automatic model(input logic s, input int e_in, input logic [19:0] m,
                       output logic [15:0] d, output logic ovf, output logic unf,
                       output logic inx, output int lat);
    int p, sh, kept, rem, half, e, mi;
    bit up;
    d = 16'h0; ovf = 0; unf = 0; inx = 0; lat = 2;
    p = -1;
    for (int i = 19; i >= 0; i--) if (m[i] && p < 0) p = i;
    if (p < 0) begin
      d = {s, 15'b0};
      return;
    end
    if (p == 19) lat = 3;
    else if (p < 18) lat = 2 + (((18 - p) < (e_in - 1)) ? (18 - p) : ((e_in > 1) ? (e_in - 1) : 0));
    mi = int'(m);
    if (p >= 10) begin
      sh   = p - 10;
      kept = mi >> sh;
      rem  = mi - (kept << sh);
      half = (sh > 0) ? (1 << (sh - 1)) : 0;
      up   = (sh > 0) && ((rem > half) || (rem == half && kept[0]));
    end else begin
      kept = mi << (10 - p);
      rem  = 0;
      up   = 0;
    end
    e   = e_in + p - 18;
    inx = (rem != 0);
    if (p < 18 && e < 1) begin
      d = {s, 15'b0}; unf = 1; inx = 1;
      return;
    end
    kept = kept + int'(up);
    if (kept == 2048) begin
      kept = 1024;
      e    = e + 1;
    end
    if (e <= 0) begin
      d = {s, 15'b0}; unf = 1; inx = 1;
    end else if (e >= 31) begin
      d = {s, 5'h1F, 10'b0}; ovf = 1; inx = 1;
    end else begin
      d = {s, 5'(e), 10'(kept - 1024)};
    end
  endtask

  // Called 1 time unit after a rising edge while the block is idle.
  task automatic run_word(input logic s, input int e, input logic [19:0] m, input int stall);
    logic [15:0] d;
    logic ov, un, ix;
    int lat, cnt;
    model(s, e, m, d, ov, un, ix, lat);
    in_valid = 1'b1; in_sign = s; in_exp = 8'(e); in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("latency", 32'(cnt), 32'(lat));
    check_eq("data", 32'(out_data), 32'(d));
    check_eq("ovf", 32'(out_ovf), 32'(ov));
    check_eq("unf", 32'(out_unf), 32'(un));
    check_eq("inexact", 32'(out_inexact), 32'(ix));
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_data", 32'(out_data), 32'(d));
      check_eq("stall_flags", 32'({out_ovf, out_unf, out_inexact}), 32'({ov, un, ix}));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    check_eq("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int e;
    logic [19:0] m;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_flags", 32'({out_ovf, out_unf, out_inexact}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_word(1'b0, 15, 20'h90000, 0);
    run_word(1'b0, 15, 20'h10000, 0);
    run_word(1'b1, 15, 20'h40080, 0);
    run_word(1'b0, 15, 20'h40180, 0);
    run_word(1'b0, 30, 20'h7FFFF, 0);
    run_word(1'b0, 1,  20'h10000, 0);
    run_word(1'b1, 15, 20'h00000, 0);
    run_word(1'b0, 0,  20'h7FFFF, 0);
    run_word(1'b0, 15, 20'h40000, 5);

    // Reset while normalising discards the word.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd15; in_mant = 20'h10000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_data", 32'(out_data), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_eq("abort_no_out", 32'(out_valid), 32'd0);
    end

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 255)) - 128;
      else e = int'($urandom_range(0, 40)) - 5;
      m = 20'($urandom) >> $urandom_range(0, 19);
      if ($urandom_range(0, 15) == 0) m = '0;
      if ($urandom_range(0, 7) == 0) m = {m[19:8], 8'h80};
      run_word(1'($urandom), e, m, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
